// File: rtl/riscv_defs.sv
// Shared definitions for the memory controller: FSM state encoding,
// load/store size codes and a helper that maps a size code to a byte count.
package riscv_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } mem_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Number of bus bytes moved for a size code; the unused code 2'b11 is
    // treated as a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_ld_ext.sv
// Load result formatting: the raw little-endian word assembled by the bus
// engine is trimmed to the access size and sign- or zero-extended.
module mem_ctrl_ld_ext
    import riscv_defs::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_word,
    output logic [31:0] o_rdata
);

    // Extension is purely combinational; bytes above the access size are ignored.
    always_comb begin
        o_rdata = i_word;
        case (i_size)
            SIZE_BYTE: o_rdata = {{24{i_signed & i_word[7]}},  i_word[7:0]};
            SIZE_HALF: o_rdata = {{16{i_signed & i_word[15]}}, i_word[15:0]};
            default:   o_rdata = i_word;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and
// load/store traffic onto an 8-bit synchronous bus (1-cycle read latency).
// Optional feature: define MEM_CTRL_IO_STALL_EN to hold IO-region writes
// while the UART TX buffer reports full.
module mem_ctrl
    import riscv_defs::*;
#(
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        if_flush,
    input  logic        ls_valid,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic        ls_signed,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    mem_state_t  r_state;
    logic        r_is_ls;
    logic        r_wr;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [2:0]  r_step;
    logic [31:0] r_base;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [31:0] r_if_data;
    logic [31:0] r_ls_rdata;

    logic [2:0]  w_nbytes;
    logic [31:0] w_step_addr;
    logic [31:0] w_prev_addr;
    logic [31:0] w_wshift;
    logic [7:0]  w_cur_byte;
    logic        w_is_io;
    logic        w_stall;
    logic        w_fetch_flush;
    logic        w_done_cycle;
    logic [31:0] w_ext;

    assign w_nbytes    = size_bytes(r_size);
    assign w_step_addr = r_base + {29'd0, r_step};
    assign w_prev_addr = w_step_addr - 32'd1;
    assign w_wshift    = r_wdata >> {r_step[1:0], 3'b000};
    assign w_cur_byte  = w_wshift[7:0];
    assign w_is_io     = (w_step_addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == 2'b11);

`ifdef MEM_CTRL_IO_STALL_EN
    assign w_stall = io_buffer_full & w_is_io;
`else
    logic w_unused_io_full;
    assign w_unused_io_full = io_buffer_full | w_is_io;
    assign w_stall = 1'b0;
`endif

    // A flush only cancels work that belongs to the fetch port.
    assign w_fetch_flush = ((r_state == ST_READ) || (r_state == ST_DONE)) && !r_is_ls && if_flush;

    mem_ctrl_ld_ext u_ld_ext (
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_word   (r_word),
        .o_rdata  (w_ext)
    );

    // Completion pulses and result ports; results show the new value during
    // the pulse and keep it afterwards from the holding registers.
    always_comb begin
        w_done_cycle = (r_state == ST_DONE) && rdy_in && !rst_in;
        if_done      = w_done_cycle && !r_is_ls && !if_flush;
        ls_done      = w_done_cycle && r_is_ls;
        if_data      = if_done ? r_word : r_if_data;
        ls_rdata     = (ls_done && !r_wr) ? w_ext : r_ls_rdata;
    end

    // Bus drive decoded from the registered FSM state. While frozen in READ,
    // the address of the capture still owed is re-presented so that mem_din
    // is valid again in the first cycle after rdy_in returns.
    always_comb begin
        mem_a    = 32'd0;
        mem_wr   = 1'b0;
        mem_dout = 8'd0;
        if (!rst_in) begin
            case (r_state)
                ST_READ: begin
                    if (rdy_in) begin
                        if (r_step < w_nbytes)
                            mem_a = w_step_addr;
                    end else if (r_step != 3'd0) begin
                        mem_a = w_prev_addr;
                    end
                end
                ST_WRITE: begin
                    if (rdy_in && !w_stall) begin
                        mem_a    = w_step_addr;
                        mem_dout = w_cur_byte;
                        mem_wr   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Transfer FSM: accept in IDLE (loads/stores first), walk the bytes, pulse done.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= ST_IDLE;
            r_step     <= 3'd0;
            r_is_ls    <= 1'b0;
            r_wr       <= 1'b0;
            r_if_data  <= 32'd0;
            r_ls_rdata <= 32'd0;
        end else if (w_fetch_flush) begin
            r_state <= ST_IDLE;
            r_step  <= 3'd0;
        end else if (rdy_in) begin
            case (r_state)
                ST_IDLE: begin
                    r_step <= 3'd0;
                    r_word <= 32'd0;
                    if (ls_valid) begin
                        r_is_ls  <= 1'b1;
                        r_wr     <= ls_wr;
                        r_size   <= ls_size;
                        r_signed <= ls_signed;
                        r_base   <= ls_addr;
                        r_wdata  <= ls_wdata;
                        r_state  <= ls_wr ? ST_WRITE : ST_READ;
                    end else if (if_valid) begin
                        r_is_ls  <= 1'b0;
                        r_wr     <= 1'b0;
                        r_size   <= SIZE_WORD;
                        r_signed <= 1'b0;
                        r_base   <= if_addr;
                        r_state  <= ST_READ;
                    end
                end
                ST_READ: begin
                    case (r_step)
                        3'd1:    r_word[7:0]   <= mem_din;
                        3'd2:    r_word[15:8]  <= mem_din;
                        3'd3:    r_word[23:16] <= mem_din;
                        3'd4:    r_word[31:24] <= mem_din;
                        default: ;
                    endcase
                    if (r_step == w_nbytes)
                        r_state <= ST_DONE;
                    else
                        r_step <= r_step + 3'd1;
                end
                ST_WRITE: begin
                    if (!w_stall) begin
                        if (r_step == w_nbytes - 3'd1)
                            r_state <= ST_DONE;
                        else
                            r_step <= r_step + 3'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_step  <= 3'd0;
                    if (r_is_ls && !r_wr)
                        r_ls_rdata <= w_ext;
                    else if (!r_is_ls)
                        r_if_data <= r_word;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, default 17, meaning IO region is any address with addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11.
REQ-002 SHALL use one clock and a synchronous, active-high reset: clk_in input 1 (system clock); rst_in input 1 (synchronous active-high reset).
REQ-003 SHALL have these ports:
- rdy_in input 1: global enable; low = freeze.
- if_valid input 1: fetch request.
- if_addr input 32: fetch byte address.
- if_done output 1: one-cycle fetch-complete pulse.
- if_data output 32: fetched word.
- if_flush input 1: cancel fetch.
- ls_valid input 1: load/store request.
- ls_wr input 1: 1 = store.
- ls_size input 2: 00 byte, 01 half, 10 word.
- ls_signed input 1: sign-extend loads.
- ls_addr input 32: data byte address.
- ls_wdata input 32: store data.
- ls_done output 1: one-cycle pulse.
- ls_rdata output 32: load result.
- mem_din input 8: bus read byte.
- mem_dout output 8: bus write byte.
- mem_a output 32: bus byte address.
- mem_wr output 1: bus write strobe.
- io_buffer_full input 1: UART TX FIFO full.

Function
REQ-004 SHALL implement states IDLE, READ, WRITE, DONE; transfers are byte-serial, little-endian; N = 1/2/4 bytes by size (fetch always 4).
REQ-005 In IDLE, SHALL accept ls_valid in preference to if_valid, latching addr/size/signed/wdata and the requester; no acceptance in any other state.
REQ-006 READ: in step k (k=0..N-1) SHALL drive mem_a=base+k with mem_wr=0; byte k is captured from mem_din one cycle later (1-cycle synchronous bus latency); READ lasts N+1 cycles.
REQ-007 WRITE: SHALL drive mem_a=base+k, mem_dout=byte k, mem_wr=1 for one cycle per byte; WRITE lasts N cycles.
REQ-008 DONE: SHALL assert exactly one of if_done/ls_done for one cycle with data valid, then return to IDLE; if_data/ls_rdata hold value until the next completion on that port.
REQ-009 Latency, request asserted in cycle 0 in IDLE: word read done in cycle 6; byte read in cycle 3; word write in cycle 5; byte write in cycle 2.
REQ-010 Loads with size byte/half SHALL sign-extend if ls_signed, else zero-extend; ls_rdata for stores is unchanged.
REQ-011 Address SHALL increment modulo 2^32; misaligned accesses SHALL complete normally.
REQ-012 if_flush SHALL abort an in-progress fetch (READ or DONE owned by fetch) to IDLE next cycle with no if_done; it SHALL NOT affect a data transfer, nor a fetch in IDLE.
REQ-013 rdy_in low SHALL freeze all state and counters and force mem_wr=0; a capture pending on mem_din SHALL be re-issued (same mem_a) after rdy_in returns.
REQ-014 In any idle/non-bus cycle mem_wr SHALL be 0 and mem_a SHALL be 0.

Reset
REQ-015 rst_in SHALL force IDLE, if_done=ls_done=0, mem_wr=0, mem_a=0, mem_dout=0, if_data=ls_rdata=0, and discard any in-flight transfer (mid-operation included) without a done pulse.

Configuration
REQ-016 With MEM_CTRL_IO_STALL_EN defined, a WRITE byte to an IO address while io_buffer_full=1 SHALL hold (mem_wr=0, step unchanged) until full drops; without it, io_buffer_full SHALL be ignored.

Structure
REQ-017 State encodings and ls_size codes SHALL live in the shared riscv_defs package.
REQ-018 Load alignment/extension SHALL be the sub-module mem_ctrl_ld_ext (combinational, size+signed+raw word -> rdata).

Verification
REQ-019 Fetch if_addr=0x100, RAM bytes 13 05 00 00 -> if_done in cycle 6, if_data=0x00000513, mem_a sequence 0x100..0x103.
REQ-020 Simultaneous if_valid and ls_valid (lb, addr 0x200, byte 0x80, signed) -> ls_done first (ls_rdata=0xFFFFFF80), fetch served after.
REQ-021 sb 0x41 to 0x30000 with io_buffer_full=1 for 5 cycles (macro on) -> mem_wr held 0 for 5 cycles, then a single write; macro off -> write in cycle 1.
REQ-022 if_flush in cycle 3 of word fetch -> no if_done, IDLE in cycle 4, new fetch accepted cycle 4.
REQ-023 rst_in mid sw at step 2 -> mem_wr=0 next cycle, no ls_done, bytes 2..3 unwritten.
REQ-024 rdy_in low 3 cycles during lhu at 0xFFFFFFFF -> second byte from 0x00000000, ls_rdata zero-extended, done delayed exactly 3 cycles.
